// File: rtl/adv7513_video_tx_pkg.sv
// rtl/adv7513_video_tx_pkg.sv - shared types and timing constants for the ADV7513 video transmitter
package adv7513_video_pkg;

    localparam int RGB_W = 24;

    // FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // 640x480@60
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // 1280x720@60
    localparam int HD720_H_ACTIVE = 1280;
    localparam int HD720_H_FP     = 110;
    localparam int HD720_H_SYNC   = 40;
    localparam int HD720_H_BP     = 220;
    localparam int HD720_V_ACTIVE = 720;
    localparam int HD720_V_FP     = 5;
    localparam int HD720_V_SYNC   = 5;
    localparam int HD720_V_BP     = 20;

    // Total period of one axis from its four segments
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/adv7513_video_tx_if.sv
// rtl/adv7513_video_tx_if.sv - upstream pixel valid/ready stream interface
interface adv7513_video_tx_if;
    import adv7513_video_pkg::*;

    logic [RGB_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;

    // Frame source side
    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    // Video transmitter side
    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/adv7513_video_tx_timing_cnt.sv
// rtl/adv7513_video_tx_timing_cnt.sv - h/v raster counters with blanking and sync decode
module video_timing_cnt
    import adv7513_video_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        eof,
    output logic        active,
    output logic        hs_raw,
    output logic        vs_raw
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Counters are 12 bits wide; larger rasters cannot be represented
    if (H_TOTAL > 4096) begin : g_h_total_chk
        $error("H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > 4096) begin : g_v_total_chk
        $error("V_TOTAL exceeds 4096");
    end

    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;

    // Next counter values: held at zero when not running, else raster scan with wrap
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run) begin
            h_d = 12'd0;
            v_d = 12'd0;
        end else if (h_q == H_LAST) begin
            h_d = 12'd0;
            v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
        end else begin
            h_d = h_q + 12'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q <= 12'd0;
            v_q <= 12'd0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Decode of the current raster position; vs only moves when v changes
    always_comb begin
        h_cnt  = h_q;
        v_cnt  = v_q;
        eof    = (h_q == H_LAST) && (v_q == V_LAST);
        active = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
        hs_raw = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
        vs_raw = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
    end

endmodule

// File: rtl/adv7513_video_tx.sv
// rtl/adv7513_video_tx.sv - parallel RGB/HS/VS/DE generator feeding the ADV7513 video input
module adv7513_video_tx
    import adv7513_video_pkg::*;
#(
    parameter int               H_ACTIVE = VGA_H_ACTIVE,
    parameter int               H_FP     = VGA_H_FP,
    parameter int               H_SYNC   = VGA_H_SYNC,
    parameter int               H_BP     = VGA_H_BP,
    parameter int               V_ACTIVE = VGA_V_ACTIVE,
    parameter int               V_FP     = VGA_V_FP,
    parameter int               V_SYNC   = VGA_V_SYNC,
    parameter int               V_BP     = VGA_V_BP,
    parameter logic             HS_POL   = 1'b0,
    parameter logic             VS_POL   = 1'b0,
    parameter logic [RGB_W-1:0] FILL_RGB = 24'h000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear_err,
    adv7513_video_tx_if.slave   pix,
    output logic [RGB_W-1:0]    hdmi_d,
    output logic                hdmi_hs,
    output logic                hdmi_vs,
    output logic                hdmi_de,
    output logic                frame_start,
    output logic                underflow,
    output logic [11:0]         x_pos,
    output logic [11:0]         y_pos
);

    state_t           state_q, state_d;
    logic [RGB_W-1:0] hdmi_d_q, hdmi_d_d;
    logic             hdmi_hs_q, hdmi_hs_d;
    logic             hdmi_vs_q, hdmi_vs_d;
    logic             hdmi_de_q, hdmi_de_d;
    logic             frame_start_q, frame_start_d;
    logic             underflow_q, underflow_d;

    logic [11:0] h_cnt, v_cnt;
    logic        eof, active, hs_raw, vs_raw;
    logic        run, take;

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .eof    (eof),
        .active (active),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw)
    );

    // Counters only advance while a frame is in flight; a drained frame still
    // accepts pixels so the upstream source sees a complete frame
    always_comb begin
        run  = (state_q == S_RUN) || (state_q == S_DRAIN);
        take = active && run;
    end

    // Next state: leaving RUN waits for end of frame so no line is truncated
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (!enable) state_d = eof ? S_IDLE : S_DRAIN;
            S_DRAIN: if (eof) state_d = enable ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next output values from the current raster position; starvation keeps timing running
    always_comb begin
        hdmi_de_d     = take;
        hdmi_d_d      = take ? (pix.pix_valid ? pix.pix_data : FILL_RGB) : '0;
        hdmi_hs_d     = (run && hs_raw) ? HS_POL : ~HS_POL;
        hdmi_vs_d     = (run && vs_raw) ? VS_POL : ~VS_POL;
        frame_start_d = run && (h_cnt == 12'd0) && (v_cnt == 12'd0);
        if (take && !pix.pix_valid) begin
            underflow_d = 1'b1;
        end else if (clear_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // FSM state and registered pin outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            hdmi_d_q      <= '0;
            hdmi_hs_q     <= ~HS_POL;
            hdmi_vs_q     <= ~VS_POL;
            hdmi_de_q     <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdmi_d_q      <= hdmi_d_d;
            hdmi_hs_q     <= hdmi_hs_d;
            hdmi_vs_q     <= hdmi_vs_d;
            hdmi_de_q     <= hdmi_de_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    // Output mapping
    always_comb begin
        pix.pix_ready = take;
        hdmi_d        = hdmi_d_q;
        hdmi_hs       = hdmi_hs_q;
        hdmi_vs       = hdmi_vs_q;
        hdmi_de       = hdmi_de_q;
        frame_start   = frame_start_q;
        underflow     = underflow_q;
        x_pos         = h_cnt;
        y_pos         = v_cnt;
    end

endmodule

// File: tb/tb_adv7513_video_tx.sv
// tb/tb_adv7513_video_tx.sv - directed self-checking bench for adv7513_video_tx
module tb_adv7513_video_tx;

    localparam logic [23:0] FILL = 24'h5A5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_err;
    logic [23:0] hdmi_d;
    logic        hdmi_hs, hdmi_vs, hdmi_de, frame_start, underflow;
    logic [11:0] x_pos, y_pos;

    adv7513_video_tx_if pix_if ();

    adv7513_video_tx #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0), .FILL_RGB (FILL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear_err   (clear_err),
        .pix         (pix_if.slave),
        .hdmi_d      (hdmi_d),
        .hdmi_hs     (hdmi_hs),
        .hdmi_vs     (hdmi_vs),
        .hdmi_de     (hdmi_de),
        .frame_start (frame_start),
        .underflow   (underflow),
        .x_pos       (x_pos),
        .y_pos       (y_pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected raster position and expected pin values for the next sample
    int          eh, ev;
    logic        p_de, p_hs, p_vs, p_fs, p_uf;
    logic [23:0] p_d;
    int          ncyc = 0;
    int          consumed;
    int          last_fs = -1;
    int          fs_gap;
    bit          drop, clr_at_drop, clr_force;
    int          guard;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_expect();
        eh = 0; ev = 0;
        p_de = 1'b0; p_d = 24'h0; p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0; p_uf = 1'b0;
    endtask

    // Check one sample point, drive the next inputs, then move to the next sample point
    task automatic cyc(input bit running);
        bit          act, vld;
        logic [23:0] dat;
        act = running && (eh < 4) && (ev < 3);
        chk("x_pos", 32'(x_pos), running ? eh : 0);
        chk("y_pos", 32'(y_pos), running ? ev : 0);
        chk("pix_ready", 32'(pix_if.pix_ready), 32'(act));
        chk("hdmi_de", 32'(hdmi_de), 32'(p_de));
        chk("hdmi_d", 32'(hdmi_d), 32'(p_d));
        chk("hdmi_hs", 32'(hdmi_hs), 32'(p_hs));
        chk("hdmi_vs", 32'(hdmi_vs), 32'(p_vs));
        chk("frame_start", 32'(frame_start), 32'(p_fs));
        chk("underflow", 32'(underflow), 32'(p_uf));
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) fs_gap = ncyc - last_fs;
            last_fs = ncyc;
        end

        dat = 24'hA50000 + 24'(ncyc);
        vld = !(drop && running && eh == 2 && ev == 1);
        pix_if.pix_data  = dat;
        pix_if.pix_valid = vld;
        clear_err = clr_force || (clr_at_drop && running && eh == 2 && ev == 1);

        if (running) begin
            p_de = act;
            p_d  = act ? (vld ? dat : FILL) : 24'h0;
            p_hs = !(eh == 5 || eh == 6);
            p_vs = (ev != 4);
            p_fs = (eh == 0 && ev == 0);
        end else begin
            p_de = 1'b0; p_d = 24'h0; p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0;
        end
        if (act && !vld) p_uf = 1'b1;
        else if (clear_err) p_uf = 1'b0;
        if (act && vld) consumed++;

        if (running) begin
            if (eh == 7) begin
                eh = 0;
                ev = (ev == 5) ? 0 : ev + 1;
            end else begin
                eh = eh + 1;
            end
        end else begin
            eh = 0; ev = 0;
        end
        ncyc++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; clear_err = 1'b0;
        pix_if.pix_data = 24'h0; pix_if.pix_valid = 1'b0;
        drop = 0; clr_at_drop = 0; clr_force = 0;
        reset_expect();
        repeat (2) @(negedge clk);

        // reset values while reset is held
        chk("rst_hs", 32'(hdmi_hs), 1);
        chk("rst_vs", 32'(hdmi_vs), 1);
        chk("rst_de", 32'(hdmi_de), 0);
        chk("rst_ready", 32'(pix_if.pix_ready), 0);
        chk("rst_x", 32'(x_pos), 0);
        reset = 1'b1;

        // 1: idle with enable low
        repeat (20) cyc(0);

        // 2: enable, always-valid source, two frames
        enable = 1'b1;
        cyc(0);
        consumed = 0;
        repeat (48) cyc(1);
        chk("consumed_f1", consumed, 12);
        consumed = 0;
        repeat (48) cyc(1);
        chk("consumed_f2", consumed, 12);

        // 3: starve pixel x=2,y=1; then clear coincident with a new underflow; then plain clear
        drop = 1; consumed = 0;
        repeat (48) cyc(1);
        chk("consumed_drop", consumed, 11);
        chk("uf_sticky", 32'(underflow), 1);
        clr_at_drop = 1;
        repeat (48) cyc(1);
        chk("uf_set_wins", 32'(underflow), 1);
        drop = 0; clr_at_drop = 0;
        clr_force = 1;
        cyc(1);
        clr_force = 0;
        cyc(1);
        chk("uf_cleared", 32'(underflow), 0);
        guard = 0;
        while (!(eh == 0 && ev == 0) && guard < 100) begin cyc(1); guard++; end
        chk("sync_t3_timeout", 32'(guard < 100), 1);

        // 4: drop enable at x=1,y=1; frame drains, then idle; re-enable from 0,0
        guard = 0;
        while (!(eh == 1 && ev == 1) && guard < 100) begin cyc(1); guard++; end
        chk("sync_t4_timeout", 32'(guard < 100), 1);
        enable = 1'b0;
        guard = 0;
        while (!(eh == 7 && ev == 5) && guard < 100) begin cyc(1); guard++; end
        chk("drain_timeout", 32'(guard < 100), 1);
        cyc(1);
        repeat (10) cyc(0);
        enable = 1'b1;
        cyc(0);
        consumed = 0;
        repeat (48) cyc(1);
        chk("consumed_reen", consumed, 12);

        // 5: brief enable drop inside a frame keeps frames back to back
        fs_gap = -1;
        guard = 0;
        while (!(eh == 0 && ev == 2) && guard < 100) begin cyc(1); guard++; end
        enable = 1'b0;
        repeat (5) cyc(1);
        enable = 1'b1;
        guard = 0;
        while (!(eh == 2 && ev == 0) && guard < 100) begin cyc(1); guard++; end
        chk("sync_t5_timeout", 32'(guard < 100), 1);
        chk("fs_gap", fs_gap, 48);

        // 6: async reset mid-line at x=3,y=0
        cyc(1);
        chk("pre_rst_x", 32'(x_pos), 3);
        reset = 1'b0;
        #1;
        chk("arst_d", 32'(hdmi_d), 0);
        chk("arst_de", 32'(hdmi_de), 0);
        chk("arst_hs", 32'(hdmi_hs), 1);
        chk("arst_vs", 32'(hdmi_vs), 1);
        chk("arst_fs", 32'(frame_start), 0);
        chk("arst_uf", 32'(underflow), 0);
        chk("arst_ready", 32'(pix_if.pix_ready), 0);
        chk("arst_x", 32'(x_pos), 0);
        chk("arst_y", 32'(y_pos), 0);
        @(negedge clk);
        enable = 1'b0; clear_err = 1'b0;
        reset_expect();
        reset = 1'b1;
        repeat (3) cyc(0);
        enable = 1'b1;
        cyc(0);
        repeat (16) cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
